judge_ctrl: RTL and testbench

Timing-judgement generator for one rhythm-game lane. It opens a timing window when a note reaches the judgement zone and grades the player's button press against the window centre. It then drives the 2-bit judgement code consumed by the score controller. Codes are emitted as finite-length bursts separated by idle (00), so the score controller's change-detect counts every judgement, including back-to-back identical ones. It also keeps a combo count for the LCD.

---
 rtl/judge_ctrl.sv | 74 +++++++
 tb/tb_judge_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/judge_ctrl.sv
// judge_ctrl: grades a lane button press against a note timing window and emits judgement bursts plus a combo count.
module judge_ctrl #(
  parameter int NORM_HALF = 12,
  parameter int PERF_HALF = 4,
  parameter int HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_note,
  input  logic       i_btn,
  output logic [1:0] o_judge,
  output logic [7:0] o_combo,
  output logic       o_busy,
  output logic       o_drop
);
  localparam int WIN_LEN = 2 * NORM_HALF + 1;
  localparam int CW = $clog2(WIN_LEN);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] LO = CW'(NORM_HALF - PERF_HALF);
  localparam logic [CW-1:0] HI = CW'(NORM_HALF + PERF_HALF);
  typedef enum logic [1:0] {IDLE, WINDOW, REPORT, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic [1:0] judge_n;
  logic [7:0] combo_n;
  logic btn_prev, press;
  assign press = i_btn & ~btn_prev;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hold_n = hold;
    judge_n = o_judge;
    combo_n = o_combo;
    case (state)
      IDLE: if (i_note) begin
        state_n = WINDOW;
        cnt_n = '0;
      end
      WINDOW: if (press || cnt == LAST) begin
        state_n = REPORT;
        hold_n = HW'(HOLD - 1);
        judge_n = !press ? 2'b01 : (cnt >= LO && cnt <= HI) ? 2'b11 : 2'b10;
        combo_n = !press ? 8'd0 : (o_combo == 8'hff) ? o_combo : o_combo + 8'd1;
      end else cnt_n = cnt + CW'(1);
      REPORT: if (hold == '0) begin
        state_n = GAP;
        judge_n = 2'b00;
      end else hold_n = hold - HW'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      o_judge <= 2'b00;
      o_combo <= 8'd0;
      o_drop <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hold <= hold_n;
      o_judge <= judge_n;
      o_combo <= combo_n;
      o_drop <= i_note && state != IDLE;
      btn_prev <= i_btn;
    end
  end
endmodule

// File: tb/tb_judge_ctrl.sv
// tb_judge_ctrl: directed checks of judge_ctrl with default parameters.
module tb_judge_ctrl;
  localparam int WL = 25;
  logic clk = 0, rst = 1, i_note = 0, i_btn = 0;
  logic [1:0] o_judge;
  logic [7:0] o_combo;
  logic o_busy, o_drop;
  int total = 0, bad = 0, njudg = 0, base;
  logic [1:0] last_j = 2'b00;
  logic [7:0] exp_combo;

  judge_ctrl dut (.clk(clk), .rst(rst), .i_note(i_note), .i_btn(i_btn),
    .o_judge(o_judge), .o_combo(o_combo), .o_busy(o_busy), .o_drop(o_drop));

  always #5 clk = ~clk;

  // change-detect monitor, as the score controller sees the code
  always @(negedge clk) begin
    if (o_judge != 2'b00 && o_judge != last_j) njudg++;
    last_j = o_judge;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // one window: k<0 means no press (Miss); ends in the first IDLE cycle
  task automatic win(input int k, input logic [1:0] code, input logic [7:0] combo);
    i_note = 1; tick; i_note = 0;
    chk("busy_arm", o_busy, 1);
    if (k < 0) begin
      repeat (WL - 1) tick;
      chk("pre_miss", o_judge, 0);
      tick;
    end else begin
      repeat (k) tick;
      i_btn = 1; tick; i_btn = 0;
    end
    for (int i = 0; i < 4; i++) begin
      chk("code", o_judge, code);
      if (i < 3) tick;
    end
    chk("combo", o_combo, combo);
    tick;
    chk("code_end", o_judge, 0);
    chk("busy_gap", o_busy, 1);
    tick;
    chk("busy_idle", o_busy, 0);
    chk("idle_code", o_judge, 0);
  endtask

  initial begin
    tick; tick;
    rst = 0;
    chk("rst_judge", o_judge, 0);
    chk("rst_combo", o_combo, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_drop", o_drop, 0);
    win(12, 2'b11, 1);
    // reset mid-WINDOW
    i_note = 1; tick; i_note = 0;
    repeat (3) tick;
    rst = 1; tick; tick; rst = 0;
    chk("mrst_judge", o_judge, 0);
    chk("mrst_combo", o_combo, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_drop", o_drop, 0);
    i_btn = 1; tick;
    chk("mrst_press", o_judge, 0);
    chk("mrst_press_busy", o_busy, 0);
    i_btn = 0; tick;
    // window boundaries
    win(0, 2'b10, 1);
    win(7, 2'b10, 2);
    win(8, 2'b11, 3);
    win(16, 2'b11, 4);
    win(17, 2'b10, 5);
    win(24, 2'b10, 6);
    win(-1, 2'b01, 0);
    win(12, 2'b11, 1);
    i_btn = 1; tick;
    win(-1, 2'b01, 0);
    i_btn = 0; tick;
    // second press during REPORT is ignored
    i_note = 1; tick; i_note = 0;
    repeat (12) tick;
    i_btn = 1; tick; i_btn = 0;
    chk("rep_code0", o_judge, 3);
    tick;
    i_btn = 1; tick; i_btn = 0;
    chk("rep_code2", o_judge, 3);
    chk("rep_combo", o_combo, 1);
    tick;
    chk("rep_code3", o_judge, 3);
    tick;
    chk("rep_end", o_judge, 0);
    chk("rep_combo2", o_combo, 1);
    tick;
    chk("rep_idle", o_busy, 0);
    // note during WINDOW is dropped
    i_note = 1; tick; i_note = 0;
    repeat (5) tick;
    i_note = 1; tick; i_note = 0;
    chk("drop_pulse", o_drop, 1);
    chk("drop_busy", o_busy, 1);
    tick;
    chk("drop_clear", o_drop, 0);
    repeat (4) tick;
    chk("drop_nocode", o_judge, 0);
    i_btn = 1; tick; i_btn = 0;
    chk("drop_code", o_judge, 3);
    chk("drop_combo", o_combo, 2);
    repeat (4) tick;
    chk("drop_end", o_judge, 0);
    tick;
    chk("drop_idle", o_busy, 0);
    // press in IDLE
    i_btn = 1; tick;
    chk("idle_press", o_judge, 0);
    chk("idle_press_busy", o_busy, 0);
    i_btn = 0; tick;
    // back-to-back at earliest re-arm
    rst = 1; tick; rst = 0;
    base = njudg;
    win(12, 2'b11, 1);
    win(12, 2'b11, 2);
    chk("b2b_count", njudg - base, 2);
    // saturation
    exp_combo = 2;
    for (int i = 0; i < 260; i++) begin
      exp_combo = (exp_combo == 8'hff) ? exp_combo : exp_combo + 8'd1;
      win(0, 2'b10, exp_combo);
    end
    chk("sat_combo", o_combo, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
